// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 types and scheduler state encoding for FPU front-end blocks.
package fpu_pkg;
    localparam int FP_WIDTH = 32;
    typedef logic [FP_WIDTH-1:0] fp32_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);
    logic [W-1:0] idx;
    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        any     = |req;
        // Walk from the farthest offset back to ptr so the closest valid index wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) gnt_idx = idx;
        end
        gnt = any ? ({{(N - 1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end
endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin time-sharing of one external FP32 adder among NUM_REQ requesters.
module fp_add_scheduler
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP_WIDTH-1:0] req_data1,
    input  logic [NUM_REQ*FP_WIDTH-1:0] req_data2,
    output logic [FP_WIDTH-1:0]       add_data1,
    output logic [FP_WIDTH-1:0]       add_data2,
    input  logic [FP_WIDTH-1:0]       add_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [FP_WIDTH-1:0]       rsp_result
);
    sched_state_t        state, state_next;
    logic [ID_W-1:0]     rr_ptr, id, gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                any;
    fp32_t               op1, op2;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign add_data1 = op1;
    assign add_data2 = op2;

    always_comb begin
        state_next = (state == IDLE && any)       ? EXEC :
                     (state == EXEC)              ? RESP :
                     (state == RESP && rsp_ready) ? IDLE : state;
        req_ready  = (n_rst && state == IDLE) ? gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rr_ptr     <= '0;
            id         <= '0;
            op1        <= '0;
            op2        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            if (state == IDLE && any) begin
                op1 <= req_data1[int'(gnt_idx)*FP_WIDTH +: FP_WIDTH];
                op2 <= req_data2[int'(gnt_idx)*FP_WIDTH +: FP_WIDTH];
                id  <= gnt_idx;
            end
            if (state == EXEC) begin
                rsp_result <= add_result;
                rsp_id     <= id;
                rsp_valid  <= 1'b1;
            end
            // The served requester drops to lowest priority for the next pick.
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
            end
        end
    end
endmodule
